// File: rtl/i2c_read_data_if.sv
// Bus bundle between the D8M read-phase stage and its sequencer / pad logic.
// Signal names follow the existing I2C path so the stage drops into it unchanged.
interface i2c_read_data_if;
   logic        GO;
   logic [7:0]  SLAVE_ADDRESS;
   logic [1:0]  BYTE_NUM;
   logic        SDAI;
   logic        SDAO;
   logic        SCLO;
   logic [15:0] DATA16;
   logic        RD_VALID;
   logic        END_OK;
   logic        ACK_OK;
   logic [7:0]  ST;

   modport slave (
      input  GO, SLAVE_ADDRESS, BYTE_NUM, SDAI,
      output SDAO, SCLO, DATA16, RD_VALID, END_OK, ACK_OK, ST
   );

   modport master (
      output GO, SLAVE_ADDRESS, BYTE_NUM, SDAI,
      input  SDAO, SCLO, DATA16, RD_VALID, END_OK, ACK_OK, ST
   );
endinterface

// File: rtl/i2c_read_data.sv
// I2C read phase for the D8M camera path: START, address+R, 1-2 data bytes with
// master ACK/NACK, STOP. One FSM state executes per PT_CK edge.
//
// state    | meaning
// IDLE     | bus released, wait for GO
// START    | SDA falls while SCL high
// A_LOW    | address bit: SCL low
// A_SET    | address bit: drive SDA
// A_HIGH   | address bit: SCL high
// A_EVAL   | address bit: SCL low, sample slave ACK after 9th bit
// R_LOW    | data bit: SCL low, SDA released
// R_HIGH   | data bit: SCL high
// R_SAMP   | data bit: sample SDA
// M_LOW    | master ACK/NACK driven with SCL low
// M_HIGH   | master ACK/NACK: SCL high
// M_END    | SCL low, store byte
// P0/P1/P2 | STOP sequence
// DONE     | publish result
// WAIT_LOW | wait for GO to drop
module i2c_read_data #(
   parameter logic [15:0] DATA_RESET = 16'h0000
) (
   input logic              RESET_N,
   input logic              PT_CK,
   i2c_read_data_if.slave   bus
);

   typedef enum logic [4:0] {
      IDLE     = 5'd0,
      START    = 5'd1,
      A_LOW    = 5'd2,
      A_SET    = 5'd3,
      A_HIGH   = 5'd4,
      A_EVAL   = 5'd5,
      R_LOW    = 5'd6,
      R_HIGH   = 5'd7,
      R_SAMP   = 5'd8,
      M_LOW    = 5'd9,
      M_HIGH   = 5'd10,
      M_END    = 5'd11,
      P0       = 5'd12,
      P1       = 5'd13,
      P2       = 5'd14,
      DONE     = 5'd15,
      WAIT_LOW = 5'd16
   } state_t;

   state_t      r_state;
   logic [8:0]  r_a;
   logic [3:0]  r_cnt;
   logic [1:0]  r_num;
   logic        r_idx;
   logic [7:0]  r_byte;
   logic [15:0] r_buf;
   logic        r_sdao;
   logic        r_sclo;
   logic [15:0] r_data16;
   logic        r_rd_valid;
   logic        r_end_ok;
   logic        r_ack_ok;
   logic        w_more;

   // a second byte follows only when two were requested and the first is in flight
   assign w_more = (r_num == 2'd2) && !r_idx;

   always_ff @(posedge PT_CK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= IDLE;
         r_a        <= 9'h1FF;
         r_cnt      <= 4'd0;
         r_num      <= 2'd1;
         r_idx      <= 1'b0;
         r_byte     <= 8'h00;
         r_buf      <= 16'h0000;
         r_sdao     <= 1'b1;
         r_sclo     <= 1'b1;
         r_data16   <= DATA_RESET;
         r_rd_valid <= 1'b0;
         r_end_ok   <= 1'b1;
         r_ack_ok   <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_sdao <= 1'b1;
               r_sclo <= 1'b1;
               if (bus.GO) begin
                  r_end_ok <= 1'b0;
                  case (bus.BYTE_NUM)
                     2'd0, 2'd1: r_num <= 2'd1;
                     default:    r_num <= 2'd2;
                  endcase
                  r_a     <= {bus.SLAVE_ADDRESS[7:1], 1'b1, 1'b1};
                  r_cnt   <= 4'd0;
                  r_buf   <= 16'h0000;
                  r_state <= START;
               end
            end
            START: begin
               r_sdao  <= 1'b0;
               r_sclo  <= 1'b1;
               r_state <= A_LOW;
            end
            A_LOW: begin
               r_sclo  <= 1'b0;
               r_state <= A_SET;
            end
            A_SET: begin
               r_sdao  <= r_a[8];
               r_a     <= {r_a[7:0], 1'b0};
               r_state <= A_HIGH;
            end
            A_HIGH: begin
               r_sclo  <= 1'b1;
               r_cnt   <= r_cnt + 4'd1;
               r_state <= A_EVAL;
            end
            A_EVAL: begin
               r_sclo <= 1'b0;
               if (r_cnt < 4'd9) begin
                  r_state <= A_LOW;
               end else begin
                  r_ack_ok <= ~bus.SDAI;
                  r_cnt    <= 4'd0;
                  r_idx    <= 1'b0;
                  r_state  <= bus.SDAI ? P0 : R_LOW;
               end
            end
            R_LOW: begin
               r_sclo  <= 1'b0;
               r_sdao  <= 1'b1;
               r_state <= R_HIGH;
            end
            R_HIGH: begin
               r_sclo  <= 1'b1;
               r_state <= R_SAMP;
            end
            R_SAMP: begin
               r_byte <= {r_byte[6:0], bus.SDAI};
               r_cnt  <= r_cnt + 4'd1;
               r_state <= (r_cnt == 4'd7) ? M_LOW : R_LOW;
            end
            M_LOW: begin
               r_sclo  <= 1'b0;
               r_sdao  <= ~w_more;
               r_state <= M_HIGH;
            end
            M_HIGH: begin
               r_sclo  <= 1'b1;
               r_state <= M_END;
            end
            M_END: begin
               r_sclo <= 1'b0;
               r_buf  <= {r_buf[7:0], r_byte};
               if (w_more) begin
                  r_idx   <= 1'b1;
                  r_cnt   <= 4'd0;
                  r_state <= R_LOW;
               end else begin
                  r_state <= P0;
               end
            end
            P0: begin
               r_sdao  <= 1'b0;
               r_sclo  <= 1'b0;
               r_state <= P1;
            end
            P1: begin
               r_sdao  <= 1'b0;
               r_sclo  <= 1'b1;
               r_state <= P2;
            end
            P2: begin
               r_sdao  <= 1'b1;
               r_sclo  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_end_ok <= 1'b1;
               if (r_ack_ok) begin
                  r_rd_valid <= 1'b1;
                  r_data16   <= (r_num == 2'd2) ? r_buf : {8'h00, r_buf[7:0]};
               end
               r_state <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (!bus.GO) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.SDAO     = r_sdao;
   assign bus.SCLO     = r_sclo;
   assign bus.DATA16   = r_data16;
   assign bus.RD_VALID = r_rd_valid;
   assign bus.END_OK   = r_end_ok;
   assign bus.ACK_OK   = r_ack_ok;
   assign bus.ST       = {3'b000, r_state};

endmodule

// File: tb/tb_i2c_read_data.sv
// Directed bench for i2c_read_data with a small I2C slave model on the bus.
`timescale 1ns/1ps
module tb_i2c_read_data;
   logic RESET_N;
   logic PT_CK;
   i2c_read_data_if bus ();

   int checks = 0;
   int errors = 0;

   // slave model controls
   logic       sl_ack;
   logic [7:0] sl_b0, sl_b1;
   logic       sl_drive;

   // bus monitor results
   int         scl_cnt;
   int         start_cnt;
   int         stop_cnt;
   logic [7:0] addr_cap;
   logic       mack18, mack27;
   int         rd_cnt;
   logic       prev_sda, prev_scl;

   i2c_read_data #(.DATA_RESET(16'h0000)) dut (
      .RESET_N (RESET_N),
      .PT_CK   (PT_CK),
      .bus     (bus)
   );

   initial PT_CK = 1'b0;
   always #5 PT_CK = ~PT_CK;

   assign bus.SDAI = bus.SDAO & sl_drive;

   initial begin
      prev_sda = 1'b1; prev_scl = 1'b1; sl_drive = 1'b1;
      scl_cnt = 0; start_cnt = 0; stop_cnt = 0;
      addr_cap = 8'h00; mack18 = 1'b0; mack27 = 1'b0;
   end

   always @(bus.SDAO, bus.SCLO) begin
      if (prev_scl && bus.SCLO && prev_sda && !bus.SDAO) begin
         start_cnt++;
         scl_cnt  = 0;
         sl_drive = 1'b1;
      end
      if (prev_scl && bus.SCLO && !prev_sda && bus.SDAO) begin
         stop_cnt++;
         sl_drive = 1'b1;
      end
      if (!prev_scl && bus.SCLO) begin
         scl_cnt++;
         if (scl_cnt >= 1 && scl_cnt <= 8) addr_cap = {addr_cap[6:0], bus.SDAO};
         if (scl_cnt == 18) mack18 = bus.SDAO;
         if (scl_cnt == 27) mack27 = bus.SDAO;
      end
      if (prev_scl && !bus.SCLO) begin
         // set up the slave's bit for the next SCL pulse
         if (scl_cnt + 1 == 9)                          sl_drive = ~sl_ack;
         else if (scl_cnt + 1 >= 10 && scl_cnt + 1 <= 17) sl_drive = sl_b0[17 - (scl_cnt + 1)];
         else if (scl_cnt + 1 >= 19 && scl_cnt + 1 <= 26) sl_drive = sl_b1[26 - (scl_cnt + 1)];
         else                                           sl_drive = 1'b1;
      end
      prev_sda = bus.SDAO;
      prev_scl = bus.SCLO;
   end

   always @(negedge PT_CK) if (bus.RD_VALID) rd_cnt++;

   task automatic run_xfer(input logic [7:0] addr, input logic [1:0] num,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic ack, input int go_hold, output int lat);
      @(negedge PT_CK);
      bus.SLAVE_ADDRESS = addr;
      bus.BYTE_NUM      = num;
      sl_b0 = b0; sl_b1 = b1; sl_ack = ack;
      rd_cnt = 0;
      bus.GO = 1'b1;
      @(posedge PT_CK);
      lat = -1;
      for (int n = 1; n <= 300; n++) begin
         @(posedge PT_CK);
         @(negedge PT_CK);
         if (n >= go_hold) bus.GO = 1'b0;
         if (bus.END_OK) begin
            lat = n;
            break;
         end
      end
      repeat (3) @(negedge PT_CK);
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      bus.GO = 1'b0; bus.SLAVE_ADDRESS = 8'h00; bus.BYTE_NUM = 2'd1;
      sl_ack = 1'b1; sl_b0 = 8'h00; sl_b1 = 8'h00; rd_cnt = 0;
      repeat (3) @(negedge PT_CK);
      checks++; if (bus.SDAO !== 1'b1) begin errors++; $display("FAIL reset_sdao got %b exp 1", bus.SDAO); end
      checks++; if (bus.SCLO !== 1'b1) begin errors++; $display("FAIL reset_sclo got %b exp 1", bus.SCLO); end
      checks++; if (bus.END_OK !== 1'b1) begin errors++; $display("FAIL reset_end_ok got %b exp 1", bus.END_OK); end
      checks++; if (bus.ACK_OK !== 1'b0) begin errors++; $display("FAIL reset_ack_ok got %b exp 0", bus.ACK_OK); end
      checks++; if (bus.RD_VALID !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", bus.RD_VALID); end
      checks++; if (bus.DATA16 !== 16'h0000) begin errors++; $display("FAIL reset_data16 got %h exp 0000", bus.DATA16); end
      checks++; if (bus.ST !== 8'd0) begin errors++; $display("FAIL reset_st got %0d exp 0", bus.ST); end
      RESET_N = 1'b1;
      repeat (2) @(negedge PT_CK);
   endtask

   task automatic test_one_byte();
      int lat; int st0; int sp0;
      st0 = start_cnt; sp0 = stop_cnt;
      run_xfer(8'h6C, 2'd1, 8'hA5, 8'h00, 1'b1, 1, lat);
      checks++; if (lat !== 68) begin errors++; $display("FAIL one_latency got %0d exp 68", lat); end
      checks++; if (addr_cap !== 8'h6D) begin errors++; $display("FAIL one_addr got %h exp 6D", addr_cap); end
      checks++; if (mack18 !== 1'b1) begin errors++; $display("FAIL one_master_nack got %b exp 1", mack18); end
      checks++; if (bus.DATA16 !== 16'h00A5) begin errors++; $display("FAIL one_data got %h exp 00A5", bus.DATA16); end
      checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL one_rd_valid got %0d exp 1", rd_cnt); end
      checks++; if (bus.ACK_OK !== 1'b1) begin errors++; $display("FAIL one_ack_ok got %b exp 1", bus.ACK_OK); end
      checks++; if (start_cnt - st0 !== 1 || stop_cnt - sp0 !== 1) begin errors++;
         $display("FAIL one_start_stop got %0d/%0d exp 1/1", start_cnt - st0, stop_cnt - sp0); end
   endtask

   task automatic test_two_byte();
      int lat;
      run_xfer(8'h42, 2'd2, 8'h12, 8'h34, 1'b1, 1, lat);
      checks++; if (lat !== 95) begin errors++; $display("FAIL two_latency got %0d exp 95", lat); end
      checks++; if (addr_cap !== 8'h43) begin errors++; $display("FAIL two_addr got %h exp 43", addr_cap); end
      checks++; if (mack18 !== 1'b0) begin errors++; $display("FAIL two_master_ack0 got %b exp 0", mack18); end
      checks++; if (mack27 !== 1'b1) begin errors++; $display("FAIL two_master_nack1 got %b exp 1", mack27); end
      checks++; if (bus.DATA16 !== 16'h1234) begin errors++; $display("FAIL two_data got %h exp 1234", bus.DATA16); end
      checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL two_rd_valid got %0d exp 1", rd_cnt); end
   endtask

   task automatic test_addr_nack();
      int lat; int sp0;
      sp0 = stop_cnt;
      run_xfer(8'h6C, 2'd2, 8'hFF, 8'hFF, 1'b0, 1, lat);
      checks++; if (lat !== 41) begin errors++; $display("FAIL nack_latency got %0d exp 41", lat); end
      checks++; if (bus.ACK_OK !== 1'b0) begin errors++; $display("FAIL nack_ack_ok got %b exp 0", bus.ACK_OK); end
      checks++; if (bus.DATA16 !== 16'h1234) begin errors++; $display("FAIL nack_data_hold got %h exp 1234", bus.DATA16); end
      checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL nack_rd_valid got %0d exp 0", rd_cnt); end
      checks++; if (stop_cnt - sp0 !== 1) begin errors++; $display("FAIL nack_stop got %0d exp 1", stop_cnt - sp0); end
   endtask

   task automatic test_reset_mid();
      int lat; bit found;
      @(negedge PT_CK);
      bus.SLAVE_ADDRESS = 8'h6C; bus.BYTE_NUM = 2'd2;
      sl_ack = 1'b1; sl_b0 = 8'h00; sl_b1 = 8'h00;
      bus.GO = 1'b1;
      found = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge PT_CK);
         if (bus.ST == 8'd7) begin found = 1; break; end
      end
      checks++; if (!found) begin errors++; $display("FAIL rmid_reach_rhigh got timeout exp ST=7"); end
      #1 RESET_N = 1'b0;
      #1;
      checks++; if ({bus.SDAO, bus.SCLO, bus.END_OK} !== 3'b111) begin errors++;
         $display("FAIL rmid_bus got %b exp 111", {bus.SDAO, bus.SCLO, bus.END_OK}); end
      checks++; if (bus.DATA16 !== 16'h0000) begin errors++; $display("FAIL rmid_data got %h exp 0000", bus.DATA16); end
      checks++; if (bus.ST !== 8'd0) begin errors++; $display("FAIL rmid_st got %0d exp 0", bus.ST); end
      bus.GO = 1'b0;
      @(negedge PT_CK);
      RESET_N = 1'b1;
      repeat (2) @(negedge PT_CK);
      run_xfer(8'h6C, 2'd1, 8'h5A, 8'h00, 1'b1, 1, lat);
      checks++; if (lat !== 68 || bus.DATA16 !== 16'h005A) begin errors++;
         $display("FAIL rmid_after got lat %0d data %h exp 68 005A", lat, bus.DATA16); end
   endtask

   task automatic test_go_handling();
      int lat; int st0;
      st0 = start_cnt;
      run_xfer(8'h6C, 2'd1, 8'h3C, 8'h00, 1'b1, 100000, lat);
      repeat (40) @(negedge PT_CK);
      checks++; if (lat !== 68 || start_cnt - st0 !== 1) begin errors++;
         $display("FAIL go_held_once got lat %0d starts %0d exp 68 1", lat, start_cnt - st0); end
      checks++; if (bus.ST !== 8'd16) begin errors++; $display("FAIL go_held_wait got %0d exp 16", bus.ST); end
      bus.GO = 1'b0;
      repeat (2) @(negedge PT_CK);
      checks++; if (bus.ST !== 8'd0) begin errors++; $display("FAIL go_release_idle got %0d exp 0", bus.ST); end
      run_xfer(8'h6C, 2'd2, 8'hBE, 8'hEF, 1'b1, 30, lat);
      checks++; if (lat !== 95 || bus.DATA16 !== 16'hBEEF) begin errors++;
         $display("FAIL go_drop_mid got lat %0d data %h exp 95 BEEF", lat, bus.DATA16); end
      run_xfer(8'h6C, 2'd1, 8'h77, 8'h00, 1'b1, 1, lat);
      checks++; if (lat !== 68 || bus.DATA16 !== 16'h0077) begin errors++;
         $display("FAIL go_second got lat %0d data %h exp 68 0077", lat, bus.DATA16); end
   endtask

   task automatic test_byte_num();
      int lat;
      run_xfer(8'h6C, 2'd0, 8'hC3, 8'h99, 1'b1, 1, lat);
      checks++; if (lat !== 68 || bus.DATA16 !== 16'h00C3) begin errors++;
         $display("FAIL bn0 got lat %0d data %h exp 68 00C3", lat, bus.DATA16); end
      run_xfer(8'h6C, 2'd3, 8'hAB, 8'hCD, 1'b1, 1, lat);
      checks++; if (lat !== 95 || bus.DATA16 !== 16'hABCD) begin errors++;
         $display("FAIL bn3 got lat %0d data %h exp 95 ABCD", lat, bus.DATA16); end
      fork
         run_xfer(8'h6C, 2'd1, 8'h81, 8'h42, 1'b1, 1, lat);
         begin
            repeat (10) @(negedge PT_CK);
            bus.BYTE_NUM = 2'd2;
         end
      join
      checks++; if (lat !== 68 || bus.DATA16 !== 16'h0081) begin errors++;
         $display("FAIL bn_change got lat %0d data %h exp 68 0081", lat, bus.DATA16); end
   endtask

   initial begin
      test_reset();
      test_one_byte();
      test_two_byte();
      test_addr_nack();
      test_reset_mid();
      test_go_handling();
      test_byte_num();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_read_data.md
Name: i2c_read_data

Overview:
- Read-phase stage that follows the pointer-write stage in the D8M camera I2C path.
- Once the pointer-write stage has set the register address and its END_OK has returned high, the sequencer pulses GO on this block.
- The block issues START, the slave address with R/W=1, reads 1 or 2 data bytes with master ACK/NACK, then issues STOP.
- One FSM state executes per PT_CK edge, the same bit-bang tick rate as the pointer writer. The result is returned on DATA16.

Parameters:
DATA_RESET, 16'h0000, reset and power-up value of DATA16

Ports:
RESET_N  in  1  asynchronous, active-low reset
PT_CK  in  1  I2C tick clock; all logic on posedge
GO  in  1  start request, level; a transfer starts when GO is sampled high in IDLE
SLAVE_ADDRESS  in  8  8-bit write address; bits [7:1] are used, bit 0 is forced to 1 (read)
BYTE_NUM  in  2  bytes to read; 1 or 2; latched at start
SDAI  in  1  SDA line readback
SDAO  out  1  SDA drive; 1 = released
SCLO  out  1  SCL drive; 1 = released
DATA16  out  16  read result
RD_VALID  out  1  one-tick pulse when DATA16 updates
END_OK  out  1  1 = idle/done, 0 = busy
ACK_OK  out  1  1 = slave ACKed the address in the last transfer
ST  out  8  FSM state, for test

Behaviour:
- Reset (async, active-low), and any reset mid-transfer:
  - ST=IDLE, SDAO=1, SCLO=1, END_OK=1, ACK_OK=0, RD_VALID=0, DATA16=DATA_RESET.
  - Internal counters cleared. The bus is released immediately.
- States, in order:
  - IDLE
  - START
  - A_LOW, A_SET, A_HIGH, A_EVAL (address bits)
  - R_LOW, R_HIGH, R_SAMP (data bits)
  - M_LOW, M_HIGH, M_END (master ACK/NACK)
  - P0, P1, P2 (stop)
  - DONE, WAIT_LOW
- IDLE: SDAO=SCLO=1, RD_VALID=0. If GO=1:
  - END_OK<=0.
  - Latch BYTE_NUM, clamped: 0 becomes 1, 3 becomes 2.
  - Load 9-bit shift A={SLAVE_ADDRESS[7:1],1'b1,1'b1}. The 9th bit releases SDA for the slave ACK.
  - Clear bit counter CNT; go to START.
- START: SDAO=0, SCLO=1 (START condition). Go to A_LOW.
- Address bit, 4 ticks per bit:
  - A_LOW: SCLO=0.
  - A_SET: SDAO<=A[8], shift A left.
  - A_HIGH: SCLO=1, CNT+1.
  - A_EVAL: SCLO=0. If CNT<9, go to A_LOW.
  - A_EVAL with CNT==9: ACK_OK<=~SDAI. On ACK go to R_LOW with byte index 0. On NACK go to P0; DATA16 is unchanged and no RD_VALID.
- Data bit, 3 ticks per bit, MSB first:
  - R_LOW: SCLO=0, SDAO=1.
  - R_HIGH: SCLO=1.
  - R_SAMP: shift SDAI into the byte register. After the 8th bit go to M_LOW.
- Master ACK, 3 ticks:
  - M_LOW: SCLO=0. SDAO=0 (ACK) if byte index < BYTE_NUM-1, else SDAO=1 (NACK).
  - M_HIGH: SCLO=1.
  - M_END: SCLO=0. Store the byte. If more bytes remain, go to R_LOW; else go to P0.
- Stop: P0 {SDAO,SCLO}=00, P1 01, P2 11.
- DONE:
  - END_OK<=1.
  - If ACK_OK: update DATA16 and pulse RD_VALID for one tick.
    - 2 bytes: DATA16={first,second}.
    - 1 byte: DATA16={8'h00,byte}.
  - Go to WAIT_LOW.
- WAIT_LOW: hold until GO=0, then go to IDLE. A GO held high does not retrigger.
- GO deasserted mid-transfer: ignored; the transfer completes.
- SDA changes only while SCLO=0, except in START and STOP.
- Latency from the IDLE edge that samples GO=1 to END_OK=1:
  - 1 byte: 68 edges.
  - 2 bytes: 95 edges.
  - Address NACK: 41 edges.

Test Plan:
- Reset mid-transfer: assert RESET_N=0 during R_HIGH → SDAO=1, SCLO=1, END_OK=1, DATA16=0000, ST=IDLE within the same cycle; a new GO after release gives a normal transfer.
- 1-byte read: SLAVE_ADDRESS=8'h6C, BYTE_NUM=1, slave model ACKs and returns 8'hA5 → SDA address bits 0110_1101; master NACK on byte 0; STOP; DATA16=16'h00A5, RD_VALID 1 tick, END_OK high 68 edges after GO sampled.
- 2-byte read: BYTE_NUM=2, slave returns 8'h12 then 8'h34 → master ACK after byte 0, NACK after byte 1; DATA16=16'h1234; END_OK at edge 95.
- Address NACK: slave leaves SDA high at the 9th clock → ACK_OK=0, STOP issued, END_OK at edge 41, DATA16 holds its previous value, no RD_VALID.
- GO handling: hold GO high across DONE → exactly one transfer; drop GO mid-read → transfer still completes; then raise GO → second transfer.
- BYTE_NUM=0 and BYTE_NUM=3 → behave as 1 and 2 bytes respectively; changing BYTE_NUM mid-transfer has no effect.
